booth_r4_seq_mult: RTL and testbench

Sequential signed multiplier that uses one shared Radix-4 Booth partial-product generator over WIDTH/2 cycles. It accepts operand pairs through a valid/ready handshake. Each cycle it steps through the multiplier's Booth triplets and accumulates shifted partial products, then holds the product until the consumer takes it. It serves as the low-area multiply path beside the combinational Booth array in the posit FMA unit.

---
 rtl/booth_pkg.sv | 26 ++
 rtl/booth_r4_digit.sv | 31 +++
 rtl/booth_r4_seq_mult.sv | 100 ++++++++++
 tb/tb_booth_r4_seq_mult.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and Booth radix-4 decode for the sequential multiplier
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Radix-4 Booth digit, range -2..+2
  typedef logic signed [2:0] booth_digit_t;

  // Map a multiplier triplet {b[2i+1], b[2i], b[2i-1]} to its Booth digit
  function automatic booth_digit_t booth_decode(input logic [2:0] trip);
    booth_digit_t d;
    case (trip)
      3'b001, 3'b010: d = 3'b001;  // +1
      3'b011:         d = 3'b010;  // +2
      3'b100:         d = 3'b110;  // -2
      3'b101, 3'b110: d = 3'b111;  // -1
      default:        d = 3'b000;  // 000 / 111
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// rtl/booth_r4_digit.sv - one radix-4 Booth partial-product generator
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]              triplet,
  input  logic [WIDTH-1:0]        a_r,
  output logic signed [WIDTH+1:0] pp
);

  booth_digit_t            digit;
  logic signed [WIDTH+1:0] a_ext;

  assign digit = booth_decode(triplet);
  // Two guard bits so that +/-2 * (-2^(W-1)) stays representable
  assign a_ext = {{2{a_r[WIDTH-1]}}, a_r};

  // Select digit * a_r
  always_comb begin
    pp = '0;
    case (digit)
      3'b001:  pp = a_ext;
      3'b010:  pp = a_ext <<< 1;
      3'b111:  pp = -a_ext;
      3'b110:  pp = -(a_ext <<< 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// rtl/booth_r4_seq_mult.sv - sequential signed radix-4 Booth multiplier, WIDTH/2 cycles per product
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int STEPS = WIDTH / 2;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_t                  state;
  logic [WIDTH-1:0]        a_r;
  logic [WIDTH:0]          b_r;
  logic [2*WIDTH-1:0]      acc;
  logic [2*WIDTH-1:0]      acc_next;
  logic [2*WIDTH-1:0]      term;
  logic [CW-1:0]           cnt;
  logic [CW:0]             shamt;
  logic [2:0]              triplet;
  logic signed [WIDTH+1:0] pp;

  // Bit offset of the current triplet and of its partial product
  assign shamt   = {cnt, 1'b0};
  assign triplet = b_r[shamt +: 3];

  booth_r4_digit #(.WIDTH(WIDTH)) u_digit (
    .triplet (triplet),
    .a_r     (a_r),
    .pp      (pp)
  );

  // Sign-extend the partial product to full width, align it, and accumulate
  always_comb begin
    term     = '0;
    term     = {{(WIDTH-2){pp[WIDTH+1]}}, pp} << shamt;
    acc_next = acc + term;
  end

  // Handshake flags decode the state register only
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  // Control FSM and datapath registers; abort overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (abort) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= {b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            product <= acc_next;
            acc     <= '0;
            cnt     <= '0;
            state   <= DONE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb/tb_booth_r4_seq_mult.sv - self-checking bench for booth_r4_seq_mult
module tb_booth_r4_seq_mult;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int n_res    = 0;

  logic [15:0] exp_q[$];

  booth_r4_seq_mult #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference model: each accepted pair's exact signed product, queued in order
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (abort) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_res++;
      end
      if (in_valid && in_ready) begin
        int p;
        p = int'($signed(a)) * int'($signed(b));
        exp_q.push_back(p[15:0]);
        n_acc++;
      end
    end
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      check("state_onehot", {29'd0, in_ready, busy, out_valid},
            (in_ready + busy + out_valid == 1) ? {29'd0, in_ready, busy, out_valid} : 32'hFFFF_FFFF);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL model_product actual=%0h required=<no pending result>", product);
        end else begin
          check("model_product", {16'd0, product}, {16'd0, exp_q[0]});
        end
      end
    end
  end

  task automatic do_txn(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [15:0] exp_p, input string nm, input int hold);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; a = ta; b = tb_v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 20);
    check({nm, "_latency"}, lat, 4);
    check({nm, "_product"}, {16'd0, product}, {16'd0, exp_p});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      check({nm, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({nm, "_hold_product"}, {16'd0, product}, {16'd0, exp_p});
      check({nm, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    check({nm, "_back_idle"}, {31'd0, in_ready}, 32'd1);
    check({nm, "_kept_product"}, {16'd0, product}, {16'd0, exp_p});
  endtask

  initial begin
    int acc0;
    int res0;
    int cyc;
    int w;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_txn(8'd3,    8'd5,    16'h000F, "t3x5",      0);
    do_txn(8'h80,   8'h80,   16'h4000, "tm128sq",   0);
    do_txn(8'h80,   8'h7F,   16'hC080, "tm128x127", 0);
    do_txn(8'hFF,   8'h01,   16'hFFFF, "tm1x1",     0);
    do_txn(8'h7F,   8'h7F,   16'h3F01, "t127sq",    10);

    // abort during the second RUN cycle
    in_valid = 1'b1; a = 8'd5; b = 8'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    // abort in IDLE beats a same-cycle operand handshake
    abort = 1'b1; in_valid = 1'b1; a = 8'd9; b = 8'd9;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    do_txn(8'd7, 8'hFA, 16'hFFD6, "t7xm6", 0);

    // reset mid-RUN
    in_valid = 1'b1; a = 8'd9; b = 8'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_product", {16'd0, product}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_txn(8'd2, 8'd2, 16'h0004, "t2x2", 0);

    // random pairs with random gaps and backpressure
    acc0 = n_acc;
    res0 = n_res;
    cyc  = 0;
    while ((n_acc - acc0) < 4000 && cyc < 60000) begin
      in_valid  = ($urandom_range(4) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    out_ready = 1'b0;
    check("rand_accepts", n_acc - acc0, 4000);
    check("rand_results", n_res - res0, n_acc - acc0);
    check("rand_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
